// File: rtl/rx_access_correlator_pkg.sv
// Shared definitions for the receive access-code correlator: state encoding,
// sync word / trailer geometry and the expected trailer bit pattern.
package rx_access_correlator_pkg;

   localparam int SW_LEN      = 64;
   localparam int WIN_W_DEF   = 10;
   localparam int TRAILER_LEN = 4;
   localparam int ERR_W       = 7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEARCH  = 2'd1,
      ST_TRAILER = 2'd2,
      ST_PASS    = 2'd3
   } state_e;

   // Trailer alternates starting with the complement of the last sync bit.
   function automatic logic trailer_bit(input logic s63, input logic [1:0] idx);
      return idx[0] ? s63 : ~s63;
   endfunction

endpackage

// File: rtl/rx_access_correlator_popcount64.sv
// Combinational 64-bit population count built as a balanced adder tree,
// shared by the access-code correlators.
module popcount64 (
   input  logic [63:0] data_i,
   output logic [6:0]  count_o
);

   logic [1:0] lvl1 [32];
   logic [2:0] lvl2 [16];
   logic [3:0] lvl3 [8];
   logic [4:0] lvl4 [4];
   logic [5:0] lvl5 [2];

   for (genvar i = 0; i < 32; i++) begin : g_lvl1
      assign lvl1[i] = {1'b0, data_i[2*i]} + {1'b0, data_i[2*i+1]};
   end

   for (genvar i = 0; i < 16; i++) begin : g_lvl2
      assign lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
   end

   for (genvar i = 0; i < 8; i++) begin : g_lvl3
      assign lvl3[i] = {1'b0, lvl2[2*i]} + {1'b0, lvl2[2*i+1]};
   end

   for (genvar i = 0; i < 4; i++) begin : g_lvl4
      assign lvl4[i] = {1'b0, lvl3[2*i]} + {1'b0, lvl3[2*i+1]};
   end

   for (genvar i = 0; i < 2; i++) begin : g_lvl5
      assign lvl5[i] = {1'b0, lvl4[2*i]} + {1'b0, lvl4[2*i+1]};
   end

   assign count_o = {1'b0, lvl5[0]} + {1'b0, lvl5[1]};

endmodule

// File: rtl/rx_access_correlator.sv
// Receive access-code correlator: hunts for the sync word with error tolerance,
// checks the trailer and then hands an aligned bit stream to the decoders.
module rx_access_correlator
   import rx_access_correlator_pkg::*;
#(
   parameter int WIN_W = WIN_W_DEF
) (
   input  logic              clk_6M,
   input  logic              rstz,
   input  logic              p_1us,
   input  logic              rxbit_raw,
   input  logic              search_en,
   input  logic              rx_end_p,
   input  logic [SW_LEN-1:0] regi_syncword,
   input  logic [ERR_W-1:0]  regi_corr_thresh,
   input  logic [WIN_W-1:0]  regi_win_len,
   input  logic              regi_trailer_chk,
   output logic              sync_found_p,
   output logic              rx_trailer_st_p,
   output logic              rxbit,
   output logic              rxbit_valid,
   output logic [ERR_W-1:0]  corr_errcnt,
   output logic              search_timeout_p,
   output logic              corr_busy
);

   state_e            state_q, state_d;
   logic              search_en_q;

   logic [SW_LEN-1:0] sr_q, sr_d, sr_shift;
   logic [ERR_W-1:0]  fill_q, fill_d;
   logic [WIN_W-1:0]  win_q, win_d, win_next;
   logic [1:0]        tcnt_q, tcnt_d;

   logic              sync_found_q, sync_found_d;
   logic              trailer_st_q, trailer_st_d;
   logic              timeout_q, timeout_d;
   logic              rxbit_q, rxbit_d;
   logic [ERR_W-1:0]  errcnt_q, errcnt_d;

   logic [ERR_W-1:0]  errs;
   logic              fill_full;
   logic              corr_hit;
   logic              win_expired;
   logic              trl_mismatch;
   logic              trl_last;

   // Correlation looks at the window as it will be after this strobe's shift.
   assign sr_shift = {rxbit_raw, sr_q[SW_LEN-1:1]};

   popcount64 u_popcount (
      .data_i  (sr_shift ^ regi_syncword),
      .count_o (errs)
   );

   assign fill_full    = (fill_q >= ERR_W'(SW_LEN - 1));
   assign corr_hit     = p_1us && fill_full && (errs <= regi_corr_thresh);
   assign win_next     = (win_q == {WIN_W{1'b1}}) ? win_q : win_q + 1'b1;
   assign win_expired  = (regi_win_len != '0) && (win_next >= regi_win_len);
   assign trl_mismatch = (rxbit_raw != trailer_bit(regi_syncword[SW_LEN-1], tcnt_q));
   assign trl_last     = (tcnt_q == 2'(TRAILER_LEN - 1));

   always_ff @(posedge clk_6M or posedge rstz) begin
      if (rstz) begin
         state_q     <= ST_IDLE;
         search_en_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         search_en_q <= search_en;
      end
   end

   // Dropping search_en overrides every other transition.
   always_comb begin
      state_d = state_q;
      if (!search_en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!search_en_q) state_d = ST_SEARCH;
            end
            ST_SEARCH: begin
               if (corr_hit) begin
                  state_d = ST_TRAILER;
               end else if (p_1us && win_expired) begin
                  state_d = ST_IDLE;
               end
            end
            ST_TRAILER: begin
               if (p_1us) begin
                  if (trl_mismatch && regi_trailer_chk) begin
                     state_d = ST_SEARCH;
                  end else if (trl_last) begin
                     state_d = ST_PASS;
                  end
               end
            end
            ST_PASS: begin
               if (rx_end_p) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      sr_d         = p_1us ? sr_shift : sr_q;
      fill_d       = fill_q;
      win_d        = win_q;
      tcnt_d       = tcnt_q;
      sync_found_d = 1'b0;
      trailer_st_d = 1'b0;
      timeout_d    = 1'b0;
      errcnt_d     = errcnt_q;
      rxbit_d      = rxbit_q;

      case (state_q)
         ST_IDLE: begin
            fill_d = '0;
            win_d  = '0;
            tcnt_d = '0;
         end
         ST_SEARCH: begin
            if (p_1us) begin
               fill_d = fill_full ? ERR_W'(SW_LEN) : fill_q + 1'b1;
               win_d  = win_next;
               if (corr_hit) begin
                  sync_found_d = 1'b1;
                  errcnt_d     = errs;
                  tcnt_d       = '0;
               end else if (win_expired) begin
                  timeout_d = 1'b1;
               end
            end
         end
         ST_TRAILER: begin
            if (p_1us) begin
               fill_d = fill_full ? ERR_W'(SW_LEN) : fill_q + 1'b1;
               win_d  = win_next;
               if (!(trl_mismatch && regi_trailer_chk)) begin
                  if (trl_last) begin
                     trailer_st_d = 1'b1;
                  end else begin
                     tcnt_d = tcnt_q + 1'b1;
                  end
               end
            end
         end
         ST_PASS: begin
            if (p_1us) rxbit_d = rxbit_raw;
         end
         default: ;
      endcase

      // Aborting the window discards everything visible to the decoders.
      if (!search_en) begin
         sync_found_d = 1'b0;
         trailer_st_d = 1'b0;
         timeout_d    = 1'b0;
         errcnt_d     = '0;
      end
      if (state_d != ST_PASS) rxbit_d = 1'b0;
   end

   always_ff @(posedge clk_6M or posedge rstz) begin
      if (rstz) begin
         sr_q         <= '0;
         fill_q       <= '0;
         win_q        <= '0;
         tcnt_q       <= '0;
         sync_found_q <= 1'b0;
         trailer_st_q <= 1'b0;
         timeout_q    <= 1'b0;
         errcnt_q     <= '0;
         rxbit_q      <= 1'b0;
      end else begin
         sr_q         <= sr_d;
         fill_q       <= fill_d;
         win_q        <= win_d;
         tcnt_q       <= tcnt_d;
         sync_found_q <= sync_found_d;
         trailer_st_q <= trailer_st_d;
         timeout_q    <= timeout_d;
         errcnt_q     <= errcnt_d;
         rxbit_q      <= rxbit_d;
      end
   end

   assign sync_found_p     = sync_found_q;
   assign rx_trailer_st_p  = trailer_st_q;
   assign search_timeout_p = timeout_q;
   assign corr_errcnt      = errcnt_q;
   assign rxbit            = rxbit_q;
   assign rxbit_valid      = (state_q == ST_PASS);
   assign corr_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx_access_correlator.sv
// Bench for rx_access_correlator: random bit streams around directed sync words,
// checked against a bit-history reference model of the receive flow.
module tb_rx_access_correlator;

   localparam logic [63:0] SW = 64'h4E7A_2B13_C5D0_9F61;

   localparam int M_IDLE = 0;
   localparam int M_HUNT = 1;
   localparam int M_TRL  = 2;
   localparam int M_PASS = 3;

   logic        clk_6M;
   logic        rstz;
   logic        p_1us;
   logic        rxbit_raw;
   logic        search_en;
   logic        rx_end_p;
   logic [63:0] regi_syncword;
   logic [6:0]  regi_corr_thresh;
   logic [9:0]  regi_win_len;
   logic        regi_trailer_chk;
   logic        sync_found_p;
   logic        rx_trailer_st_p;
   logic        rxbit;
   logic        rxbit_valid;
   logic [6:0]  corr_errcnt;
   logic        search_timeout_p;
   logic        corr_busy;

   int          vectors;
   int          miscompares;

   int          m_mode;
   bit          hist[$];
   int          m_win;
   int          m_tidx;
   logic [6:0]  m_err;
   logic        m_rxbit;
   logic        exp_sync;
   logic        exp_trl;
   logic        exp_to;

   int          strobe_idx;
   int          sync_at;
   int          to_at;
   int          trl_at;

   logic [63:0] word;

   rx_access_correlator dut (
      .clk_6M           (clk_6M),
      .rstz             (rstz),
      .p_1us            (p_1us),
      .rxbit_raw        (rxbit_raw),
      .search_en        (search_en),
      .rx_end_p         (rx_end_p),
      .regi_syncword    (regi_syncword),
      .regi_corr_thresh (regi_corr_thresh),
      .regi_win_len     (regi_win_len),
      .regi_trailer_chk (regi_trailer_chk),
      .sync_found_p     (sync_found_p),
      .rx_trailer_st_p  (rx_trailer_st_p),
      .rxbit            (rxbit),
      .rxbit_valid      (rxbit_valid),
      .corr_errcnt      (corr_errcnt),
      .search_timeout_p (search_timeout_p),
      .corr_busy        (corr_busy)
   );

   initial clk_6M = 1'b0;
   always #5 clk_6M = ~clk_6M;

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      checkOutput({tag, ".sync_found_p"},     16'(sync_found_p),     16'(exp_sync));
      checkOutput({tag, ".rx_trailer_st_p"},  16'(rx_trailer_st_p),  16'(exp_trl));
      checkOutput({tag, ".search_timeout_p"}, 16'(search_timeout_p), 16'(exp_to));
      checkOutput({tag, ".corr_errcnt"},      16'(corr_errcnt),      16'(m_err));
      checkOutput({tag, ".rxbit"},            16'(rxbit),            16'(m_rxbit));
      checkOutput({tag, ".rxbit_valid"},      16'(rxbit_valid),      16'(m_mode == M_PASS));
      checkOutput({tag, ".corr_busy"},        16'(corr_busy),        16'(m_mode != M_IDLE));
   endtask

   task automatic model_reset();
      m_mode   = M_IDLE;
      m_err    = '0;
      m_rxbit  = 1'b0;
      exp_sync = 1'b0;
      exp_trl  = 1'b0;
      exp_to   = 1'b0;
      hist.delete();
   endtask

   // Reference: keep the last 64 received bits and re-count errors from scratch.
   task automatic model_strobe(input bit b);
      int  errs;
      bit  want;
      exp_sync = 1'b0;
      exp_trl  = 1'b0;
      exp_to   = 1'b0;
      case (m_mode)
         M_HUNT: begin
            hist.push_back(b);
            if (hist.size() > 64) void'(hist.pop_front());
            m_win++;
            errs = -1;
            if (hist.size() == 64) begin
               errs = 0;
               for (int k = 0; k < 64; k++) if (hist[k] != regi_syncword[k]) errs++;
            end
            if (errs >= 0 && errs <= int'(regi_corr_thresh)) begin
               exp_sync = 1'b1;
               m_err    = 7'(errs);
               m_mode   = M_TRL;
               m_tidx   = 0;
            end else if (regi_win_len != 0 && m_win >= int'(regi_win_len)) begin
               exp_to = 1'b1;
               m_mode = M_IDLE;
            end
         end
         M_TRL: begin
            hist.push_back(b);
            if (hist.size() > 64) void'(hist.pop_front());
            m_win++;
            want = (m_tidx % 2 == 0) ? !regi_syncword[63] : regi_syncword[63];
            if (b != want && regi_trailer_chk) begin
               m_mode = M_HUNT;
            end else if (m_tidx == 3) begin
               exp_trl = 1'b1;
               m_mode  = M_PASS;
            end else begin
               m_tidx++;
            end
         end
         M_PASS: m_rxbit = b;
         default: ;
      endcase
   endtask

   task automatic applyStimulus(input bit b);
      rxbit_raw = b;
      p_1us     = 1'b1;
      @(posedge clk_6M); #1;
      p_1us = 1'b0;
      strobe_idx++;
      model_strobe(b);
      check_all($sformatf("strobe%0d", strobe_idx));
      if (sync_found_p === 1'b1)     sync_at = strobe_idx;
      if (search_timeout_p === 1'b1) to_at   = strobe_idx;
      if (rx_trailer_st_p === 1'b1)  trl_at  = strobe_idx;
      exp_sync = 1'b0;
      exp_trl  = 1'b0;
      exp_to   = 1'b0;
      @(posedge clk_6M); #1;
      check_all($sformatf("gap%0d", strobe_idx));
      @(posedge clk_6M); #1;
   endtask

   task automatic random_bits(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'($urandom));
   endtask

   task automatic send_word(input logic [63:0] w);
      for (int k = 0; k < 64; k++) applyStimulus(w[k]);
   endtask

   task automatic send_nibble(input logic [3:0] t);
      for (int k = 3; k >= 0; k--) applyStimulus(t[k]);
   endtask

   task automatic flip_word(input int nflip, output logic [63:0] w);
      logic [63:0] used;
      int          p;
      int          n;
      w    = SW;
      used = '0;
      n    = 0;
      while (n < nflip) begin
         p = int'($urandom_range(63));
         if (!used[p]) begin
            used[p] = 1'b1;
            w[p]    = ~w[p];
            n++;
         end
      end
   endtask

   task automatic configure(input logic [6:0] thresh, input logic [9:0] wlen, input logic chk);
      regi_syncword    = SW;
      regi_corr_thresh = thresh;
      regi_win_len     = wlen;
      regi_trailer_chk = chk;
   endtask

   task automatic open_window();
      search_en = 1'b1;
      @(posedge clk_6M); #1;
      m_mode     = M_HUNT;
      m_win      = 0;
      hist.delete();
      strobe_idx = 0;
      sync_at    = 0;
      to_at      = 0;
      trl_at     = 0;
      check_all("open");
   endtask

   task automatic close_window();
      search_en = 1'b0;
      @(posedge clk_6M); #1;
      model_reset();
      check_all("close");
   endtask

   task automatic end_packet();
      rx_end_p = 1'b1;
      @(posedge clk_6M); #1;
      rx_end_p = 1'b0;
      m_mode   = M_IDLE;
      m_rxbit  = 1'b0;
      check_all("rx_end");
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rstz        = 1'b1;
      p_1us       = 1'b0;
      rxbit_raw   = 1'b0;
      search_en   = 1'b0;
      rx_end_p    = 1'b0;
      m_win       = 0;
      m_tidx      = 0;
      strobe_idx  = 0;
      sync_at     = 0;
      to_at       = 0;
      trl_at      = 0;
      configure(7'd0, 10'd0, 1'b1);
      model_reset();
      repeat (3) @(posedge clk_6M);
      #1;
      check_all("reset");
      rstz = 1'b0;
      @(posedge clk_6M); #1;
      check_all("post_reset");

      $display("[TB] exact match, threshold 0");
      configure(7'd0, 10'd0, 1'b1);
      open_window();
      random_bits(20);
      send_word(SW);
      checkOutput("exact.sync_at", 16'(sync_at), 16'd84);
      checkOutput("exact.errcnt", 16'(corr_errcnt), 16'd0);
      send_nibble(4'b1010);
      checkOutput("exact.trl_at", 16'(trl_at), 16'd88);
      random_bits(8);
      end_packet();
      close_window();

      $display("[TB] seven bit errors, threshold 7");
      configure(7'd7, 10'd0, 1'b1);
      flip_word(7, word);
      open_window();
      random_bits(10);
      send_word(word);
      checkOutput("err7.sync_at", 16'(sync_at), 16'd74);
      checkOutput("err7.errcnt", 16'(corr_errcnt), 16'd7);
      send_nibble(4'b1010);
      random_bits(4);
      end_packet();
      close_window();

      $display("[TB] eight bit errors, window 200");
      configure(7'd7, 10'd200, 1'b1);
      flip_word(8, word);
      open_window();
      random_bits(20);
      send_word(word);
      random_bits(121);
      checkOutput("err8.sync_at", 16'(sync_at), 16'd0);
      checkOutput("err8.to_at", 16'(to_at), 16'd200);
      close_window();

      $display("[TB] trailer mismatch with check enabled");
      configure(7'd0, 10'd0, 1'b1);
      open_window();
      random_bits(10);
      send_word(SW);
      send_nibble(4'b1011);
      checkOutput("trlchk.trl_at", 16'(trl_at), 16'd0);
      checkOutput("trlchk.busy", 16'(corr_busy), 16'd1);
      random_bits(5);
      close_window();

      $display("[TB] trailer mismatch with check disabled");
      configure(7'd0, 10'd0, 1'b0);
      open_window();
      random_bits(10);
      send_word(SW);
      send_nibble(4'b1011);
      checkOutput("trlnochk.trl_at", 16'(trl_at), 16'd78);
      random_bits(3);
      close_window();

      $display("[TB] window 100 without sync word");
      configure(7'd0, 10'd100, 1'b1);
      open_window();
      random_bits(105);
      checkOutput("win100.to_at", 16'(to_at), 16'd100);
      close_window();

      $display("[TB] abort at strobe 50");
      configure(7'd0, 10'd100, 1'b1);
      open_window();
      random_bits(50);
      close_window();
      random_bits(60);
      checkOutput("abort.to_at", 16'(to_at), 16'd0);

      $display("[TB] partial fill, threshold 64");
      configure(7'd64, 10'd0, 1'b0);
      open_window();
      random_bits(64);
      checkOutput("fill.sync_at", 16'(sync_at), 16'd64);
      random_bits(7);

      $display("[TB] asynchronous reset in PASS");
      checkOutput("prereset.valid", 16'(rxbit_valid), 16'd1);
      #2;
      rstz = 1'b1;
      #1;
      model_reset();
      check_all("async_reset");
      search_en = 1'b0;
      @(posedge clk_6M); #4;
      rstz = 1'b0;
      @(posedge clk_6M); #1;
      check_all("reset_release");
      open_window();
      random_bits(63);
      checkOutput("refill.no_early_hit", 16'(sync_at), 16'd0);
      random_bits(1);
      checkOutput("refill.sync_at", 16'(sync_at), 16'd64);
      close_window();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
